// File: rtl/mod_addsub_p_param_if.sv
// Start/done request bundle between the point-arithmetic controller
// and the modular add/sub unit.
interface mod_addsub_p_param_if #(
    parameter int W = 256
);
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] c;

    modport master (
        output start, mode, a, b,
        input  busy, done, c
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, c
    );
endinterface

// File: rtl/mod_addsub_p_param.sv
// Multi-cycle modular add/sub/neg/dbl over an odd W-bit prime P.
// Accepts unreduced operands; result is always canonical in [0, P-1].
module mod_addsub_p_param #(
    parameter int           W = 256,
    parameter logic [W-1:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF
) (
    input logic clk,
    input logic rst,
    mod_addsub_p_param_if.slave bus
);
    // Single-subtraction reduction only holds when 2^W < 2P.
    generate
        if (!P[W-1]) begin : g_p_check
            $fatal(1, "mod_addsub_p_param: P[W-1] must be 1");
        end
    endgenerate

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_RED  = 5'b00010;
    localparam logic [4:0] S_OP   = 5'b00100;
    localparam logic [4:0] S_COR  = 5'b01000;
    localparam logic [4:0] S_FIN  = 5'b10000;

    localparam int I_IDLE = 0;
    localparam int I_RED  = 1;
    localparam int I_OP   = 2;
    localparam int I_COR  = 3;
    localparam int I_FIN  = 4;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_NEG = 2'b10;
    localparam logic [1:0] M_DBL = 2'b11;

    localparam logic [W:0] PX = {1'b0, P};

    logic [4:0]   state;
    logic [1:0]   md;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   r;
    logic [W-1:0] c_q;

    logic [W-1:0] a_red;
    logic [W-1:0] b_red;
    logic [W:0]   r_nxt;
    logic [W-1:0] c_nxt;

    always_comb begin
        a_red = (ra >= P) ? ra - P : ra;
        b_red = (rb >= P) ? rb - P : rb;
    end

    always_comb begin
        r_nxt = '0;
        unique case (md)
            M_ADD: r_nxt = {1'b0, ra} + {1'b0, rb};
            M_SUB: r_nxt = {1'b0, ra} - {1'b0, rb};
            M_NEG: r_nxt = PX - {1'b0, rb};
            M_DBL: r_nxt = {ra, 1'b0};
            default: r_nxt = '0;
        endcase
    end

    // r[W] flags a borrow in sub; adding P back wraps into range.
    always_comb begin
        c_nxt = '0;
        unique case (md)
            M_ADD, M_DBL: c_nxt = (r >= PX) ? W'(r - PX) : r[W-1:0];
            M_SUB:        c_nxt = r[W] ? W'(r + PX) : r[W-1:0];
            M_NEG:        c_nxt = (rb == '0) ? '0 : r[W-1:0];
            default:      c_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            md    <= '0;
            ra    <= '0;
            rb    <= '0;
            r     <= '0;
            c_q   <= '0;
        end else begin
            unique case (1'b1)
                state[I_IDLE]: begin
                    if (bus.start) begin
                        ra    <= bus.a;
                        rb    <= bus.b;
                        md    <= bus.mode;
                        state <= S_RED;
                    end
                end
                state[I_RED]: begin
                    ra    <= a_red;
                    rb    <= b_red;
                    state <= S_OP;
                end
                state[I_OP]: begin
                    r     <= r_nxt;
                    state <= S_COR;
                end
                state[I_COR]: begin
                    c_q   <= c_nxt;
                    state <= S_FIN;
                end
                state[I_FIN]: state <= S_IDLE;
                default:      state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = !state[I_IDLE];
    assign bus.done = state[I_FIN];
    assign bus.c    = c_q;

endmodule

// File: tb/tb_mod_addsub_p_param.sv
// Directed and random checks of mod_addsub_p_param at SM2 p (W=256)
// and at a small prime (W=8), with a queue of expected results.
module tb_mod_addsub_p_param;
    localparam logic [255:0] PP =
        256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
    localparam logic [255:0] PS = 256'd251;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_addsub_p_param_if #(.W(256)) pb ();
    mod_addsub_p_param_if #(.W(8))   sb ();

    mod_addsub_p_param dut_p (
        .clk (clk),
        .rst (rst),
        .bus (pb)
    );

    mod_addsub_p_param #(.W(8), .P(8'hFB)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] sbq[$];

    function automatic logic dn(bit sel);
        return sel ? sb.done : pb.done;
    endfunction

    function automatic logic bs(bit sel);
        return sel ? sb.busy : pb.busy;
    endfunction

    function automatic logic [255:0] cv(bit sel);
        return sel ? {248'b0, sb.c} : pb.c;
    endfunction

    // Reference via wide modulo arithmetic on fully reduced operands.
    function automatic logic [255:0] ref_op(logic [1:0] m, logic [255:0] a,
                                            logic [255:0] b, logic [255:0] p);
        logic [511:0] pp, ar, br, res;
        pp = {256'b0, p};
        ar = {256'b0, a} % pp;
        br = {256'b0, b} % pp;
        case (m)
            2'b00:   res = (ar + br) % pp;
            2'b01:   res = (ar + pp - br) % pp;
            2'b10:   res = (pp - br) % pp;
            default: res = (2 * ar) % pp;
        endcase
        return res[255:0];
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit sel, logic [1:0] m, logic [255:0] a, logic [255:0] b);
        if (sel) begin
            sb.start = 1'b1;
            sb.mode  = m;
            sb.a     = a[7:0];
            sb.b     = b[7:0];
        end else begin
            pb.start = 1'b1;
            pb.mode  = m;
            pb.a     = a;
            pb.b     = b;
        end
    endtask

    task automatic release_start();
        pb.start = 1'b0;
        sb.start = 1'b0;
    endtask

    // Called at the falling edge just after the capture edge.
    task automatic finish_op(bit sel, string tag);
        int cyc;
        int bc;
        logic [255:0] exp;
        cyc = 0;
        bc  = 0;
        while (1) begin
            cyc++;
            if (bs(sel)) bc++;
            if (dn(sel) || cyc >= 20) break;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 256'(cyc), 256'd4);
        chk({tag, ".busy_cycles"}, 256'(bc), 256'd4);
        exp = (sbq.size() > 0) ? sbq.pop_front() : 'x;
        chk({tag, ".c"}, cv(sel), exp);
        @(negedge clk);
        chk({tag, ".done_drop"}, 256'(dn(sel)), 256'd0);
        chk({tag, ".idle"}, 256'(bs(sel)), 256'd0);
    endtask

    task automatic op(bit sel, logic [1:0] m, logic [255:0] a, logic [255:0] b,
                      logic [255:0] exp, string tag);
        @(negedge clk);
        drive(sel, m, a, b);
        sbq.push_back(exp);
        @(negedge clk);
        release_start();
        finish_op(sel, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [1:0]   m;
        logic [255:0] ra, rb;

        rst = 1'b1;
        pb.start = 1'b0; pb.mode = '0; pb.a = '0; pb.b = '0;
        sb.start = 1'b0; sb.mode = '0; sb.a = '0; sb.b = '0;
        repeat (2) @(negedge clk);
        chk("rst.c", pb.c, 256'd0);
        chk("rst.busy", 256'(pb.busy), 256'd0);
        chk("rst.done", 256'(pb.done), 256'd0);
        chk("rst.c8", cv(1'b1), 256'd0);
        rst = 1'b0;

        op(0, 2'b00, PP - 1, 256'd1, 256'd0, "add_wrap");
        op(0, 2'b00, 256'd5, 256'd7, 256'd12, "add_small");
        op(0, 2'b01, 256'd0, 256'd1, PP - 1, "sub_borrow");
        op(0, 2'b01, 256'd9, 256'd9, 256'd0, "sub_equal");
        op(0, 2'b00, PP + 5, 256'd3, 256'd8, "add_unred");
        op(0, 2'b11, PP - 1, 256'd0, PP - 2, "dbl_top");
        op(0, 2'b10, 256'd0, 256'd0, 256'd0, "neg_zero");
        op(0, 2'b10, 256'd0, 256'd1, PP - 1, "neg_one");
        op(0, 2'b10, 256'd0, PP, 256'd0, "neg_p");

        // Held start: ignored while busy and in FIN, re-captured at k+5.
        @(negedge clk);
        drive(0, 2'b00, 256'd1, 256'd2);
        sbq.push_back(256'd3);
        @(negedge clk);
        pb.a = 256'd100;
        finish_op(0, "hold_first");
        sbq.push_back(256'd102);
        @(negedge clk);
        chk("hold.recapture", 256'(pb.busy), 256'd1);
        release_start();
        finish_op(0, "hold_second");

        // Reset on the edge that would enter OP.
        @(negedge clk);
        drive(0, 2'b01, 256'd0, 256'd1);
        @(negedge clk);
        release_start();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 256'(pb.busy), 256'd0);
        chk("abort.done", 256'(pb.done), 256'd0);
        chk("abort.c", pb.c, 256'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pb.done) seen = 1'b1;
        end
        chk("abort.no_done", 256'(seen), 256'd0);
        op(0, 2'b00, 256'd2, 256'd3, 256'd5, "after_abort");

        op(1, 2'b00, 256'd250, 256'd10, 256'd9, "w8_add");
        op(1, 2'b01, 256'd3, 256'd250, 256'd4, "w8_sub");
        op(1, 2'b11, 256'd255, 256'd0, 256'd8, "w8_dbl");
        op(1, 2'b10, 256'd0, 256'd251, 256'd0, "w8_neg");

        for (int i = 0; i < 12; i++) begin
            m  = 2'($urandom_range(0, 3));
            ra = 256'($urandom_range(0, 255));
            rb = 256'($urandom_range(0, 255));
            op(1, m, ra, rb, ref_op(m, ra, rb, PS), "w8_rand");
        end

        for (int i = 0; i < 6; i++) begin
            m  = 2'($urandom_range(0, 3));
            ra = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            rb = (i % 2 == 0) ? PP + 256'($urandom_range(0, 100))
                              : {$urandom(), $urandom(), $urandom(), $urandom(),
                                 $urandom(), $urandom(), $urandom(), $urandom()};
            op(0, m, ra, rb, ref_op(m, ra, rb, PP), "w256_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_addsub_p_param.md
Name: mod_addsub_p_param

Overview:
Parametrised successor to the SM2 fixed-prime modular add/sub unit. Computes one of four modular operations over a W-bit odd prime P: add, subtract, negate, double. Inputs are accepted unreduced; the result is always canonical in [0, P-1]. It sits beside the modular multiplier in the SM2 point-arithmetic datapath and is driven by the point add/double controller through a start/done handshake.

Parameters:
W, 256, operand and result width in bits.
P, 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF, modulus (SM2 p). Constraint: P[W-1]=1, so 2^W < 2P; elaboration-time check required.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  request pulse; sampled only in IDLE.
mode  input  2  00 add (a+b), 01 sub (a-b), 10 neg (-b), 11 dbl (2a); all mod P.
a  input  W  operand A, any value in [0, 2^W-1].
b  input  W  operand B, any value in [0, 2^W-1].
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse, high while in FIN.
c  output  W  registered result; holds its value until the next FIN.

Behaviour:
- Reset: one clock with rst=1 forces state IDLE, c=0, done=0, busy=0 and clears internal registers. Applies in any state and aborts any operation in flight; no done is issued for it.
- Sequential states (one-hot): IDLE, RED, OP, COR, FIN.
- IDLE:
  - start=1: capture a, b and mode; go to RED.
  - Otherwise stay in IDLE.
- RED: a' = (a >= P) ? a-P : a, and likewise b'. One subtraction is sufficient because of the P[W-1] constraint. Go to OP.
- OP: compute a (W+1)-bit raw value r:
  - add: r = a' + b'.
  - sub: r = a' - b' in two's complement (W+1 bits).
  - neg: r = P - b'.
  - dbl: r = a' + a'.
  - Go to COR.
- COR: correct r into [0, P-1] and write c:
  - add/dbl: c = (r >= P) ? r-P : r.
  - sub: c = r[W] ? r+P : r, i.e. add P back when a' < b'.
  - neg: c = (b' == 0) ? 0 : r.
  - Go to FIN.
- FIN: done=1; go to IDLE unconditionally.
- Latency: start sampled at edge k gives done high between edges k+3 and k+4. c is valid from edge k+3 and stays stable until a later operation reaches COR.
- Throughput: one operation per 5 cycles. Earliest next accept is at edge k+5, since start is ignored in FIN.
- start while busy is ignored: no queueing, and no effect on captured operands.
- a, b and mode may change freely after the capture edge.
- Equal operands: sub with a'=b' yields 0. Result c=P never occurs.
- All internal arithmetic is at most W+1 bits. No multi-cycle paths.

Test Plan:
1. Default P, add, a=P-1, b=1 -> done at edge k+3..k+4, c=0. Then add, a=5, b=7 -> c=12.
2. Default P, sub, a=0, b=1 -> c=P-1 (FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFE). Then sub, a=9, b=9 -> c=0.
3. Unreduced inputs, default P:
   - add, a=P+5, b=3 -> c=8.
   - dbl, a=P-1 -> c=P-2.
   - neg, b=0 -> c=0.
   - neg, b=1 -> c=P-1.
4. Handshake: pulse start (add 1+2), then hold start=1 with a=100 through busy cycles.
   - Expect c=3 and a single done pulse.
   - The next capture occurs at edge k+5, followed by a second done with c=102 (add 100+2 if b=2 held).
   - busy is high for exactly 4 cycles per operation.
5. Reset mid-operation: start sub 0-1, assert rst at the edge entering OP.
   - Expect state IDLE, c=0, no done.
   - A fresh add 2+3 then gives c=5.
6. W=8, P=8'hFB (251):
   - add 250+10 -> 9.
   - sub 3-250 -> 4.
   - dbl 255 -> 8, since a'=4.
   - neg 251 -> 0.
